instr_cache_refill_ctrl: RTL and testbench
==========================================

Name: instr_cache_refill_ctrl

Overview:
- Sits directly upstream of instr_cache_set_multi and drives its ic_repl_grant_i and rep_word_i inputs.
- On an instruction-cache miss, it latches the block-aligned miss address and issues one read request to the memory side.
- It collects B/8 64-bit beats and streams each beat to the cache set as a registered rep_word_o with ic_repl_grant_o asserted.
- It holds the fetch stall until the refill completes.

Parameters:
- B, 64, cache block size in bytes; power of two, ≥16.
- ADDR_W, 32, address width in bits.
- BEATS, B/8, derived (localparam): number of 64-bit beats per block.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- miss_i  in  1  OR of the cache-set miss indications for the current fetch.
- miss_addr_i  in  ADDR_W  fetch PC that missed.
- flush_i  in  1  synchronous abort (pipeline redirect).
- mem_req_o  out  1  read request to memory.
- mem_addr_o  out  ADDR_W  block-aligned request address.
- mem_ack_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  read beat valid.
- mem_rdata_i  in  64  read beat data.
- ic_repl_grant_o  out  1  replacement-word strobe to the cache set.
- rep_word_o  out  64  replacement word to the cache set.
- refill_busy_o  out  1  high in any state other than IDLE; used as the fetch stall.
- refill_done_o  out  1  one-cycle pulse when the block is complete.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - State returns to IDLE and the beat counter clears to 0.
  - mem_req_o, ic_repl_grant_o, refill_busy_o and refill_done_o go to 0.
  - mem_addr_o and rep_word_o go to 0.
  - Reset during any state abandons the refill. Late mem_rvalid_i beats arriving after reset are ignored, because they only count in FILL.
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE:
  - If miss_i=1 and flush_i=0: capture mem_addr_o = miss_addr_i with the low log2(B) bits forced to 0, then go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - mem_req_o=1; mem_addr_o is held stable.
  - If mem_ack_i=1, go to FILL next cycle with the counter at 0.
  - mem_req_o drops in the cycle after ack.
  - mem_rvalid_i is ignored in REQ.
- FILL:
  - Each cycle with mem_rvalid_i=1: rep_word_o <= mem_rdata_i, ic_repl_grant_o <= 1 in the next cycle (1-cycle latency), and the counter increments.
  - Each cycle with mem_rvalid_i=0: ic_repl_grant_o <= 0 in the next cycle, and rep_word_o holds.
  - Gaps between beats are allowed. The cache set consumes words only on grant cycles, so beat order is preserved.
  - The beat with counter = BEATS-1 moves the FSM to DONE. The counter wraps to 0.
  - Beat k carries block bytes [8k+7:8k] (little-endian, beat 0 = lowest address).
- DONE:
  - Lasts exactly one cycle. ic_repl_grant_o is high for the last beat; refill_done_o=1.
  - miss_i is not sampled in DONE. Next state is IDLE, where miss_i is re-sampled; the cache now reports a hit.
- flush_i:
  - In REQ or FILL: next state is IDLE, ic_repl_grant_o <= 0, counter <= 0, refill_done_o stays 0.
  - If flush_i arrives in REQ after mem_ack_i was already given, the remaining beats are dropped, because the FSM no longer sits in FILL.
  - flush_i has no effect in DONE; the done pulse still occurs.
  - flush_i=1 in IDLE blocks the start of a refill.
- Simultaneous events:
  - miss_i in IDLE with flush_i=1: stay in IDLE.
  - mem_ack_i and mem_rvalid_i in the same REQ cycle: the rvalid is ignored.
- Busy and hits:
  - refill_busy_o is registered state-derived: 1 in REQ, FILL and DONE.
  - The total busy time for zero-gap memory is 1 (REQ, ack same cycle) + BEATS + 1 (DONE) cycles. For B=64 this is 10 cycles.
  - The first hit is available the cycle after DONE.

Test Plan:
- Basic refill (zero gaps):
  - Stimulus: reset, then miss_i=1 with miss_addr_i=0x0000_1234; ack in the first REQ cycle; 8 back-to-back beats D0..D7.
  - Required: mem_addr_o=0x0000_1200; ic_repl_grant_o high for exactly 8 consecutive cycles, each carrying rep_word_o=Dk one cycle after beat k; refill_done_o pulses once; busy lasts 10 cycles.
- Gapped beats:
  - Stimulus: insert 2 idle cycles after beats 1 and 5.
  - Required: grant shows the gaps; 8 grants total in order; refill_done_o fires only after D7.
- Delayed ack:
  - Stimulus: hold mem_ack_i=0 for 5 cycles; pulse mem_rvalid_i during REQ.
  - Required: mem_req_o stays 1 and mem_addr_o stays stable; no grant until FILL; the stray beat is not counted.
- Flush mid-FILL:
  - Stimulus: flush_i after beat 3.
  - Required: next cycle the FSM is in IDLE with grant=0, busy=0, no done pulse; a new miss at 0x40 produces mem_addr_o=0x40 and a full 8-beat refill.
- Async reset mid-FILL:
  - Stimulus: drive reset_i=0 between clock edges during beat 4.
  - Required: all outputs go to 0 immediately; after release, beats still arriving are ignored and the FSM stays in IDLE.
- Integration with instr_cache_set_multi (E=4):
  - Stimulus: four misses with tags 500, 600, 700, 800.
  - Required: each is followed by cache_set_miss=0 the cycle after DONE, and data_o equals the low 32 bits of D0.

Source files
------------

// File: rtl/instr_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// instr_cache_refill_ctrl
//
// Refill controller for the instruction cache. On a fetch miss it latches
// the block-aligned miss address, issues one read request to memory, then
// streams the BEATS 64-bit beats of the block to the cache set as registered
// replacement words, each qualified by ic_repl_grant_o. The fetch stall
// (refill_busy_o) is held from the request until the block is complete.
//
// Ports:
//   clk_i            clock
//   reset_i          asynchronous active-low reset
//   miss_i           OR of the cache-set miss indications for this fetch
//   miss_addr_i      fetch PC that missed
//   flush_i          synchronous abort (pipeline redirect)
//   mem_req_o        read request to memory
//   mem_addr_o       block-aligned request address
//   mem_ack_i        memory accepted the request
//   mem_rvalid_i     read beat valid
//   mem_rdata_i      read beat data (beat 0 = lowest address)
//   ic_repl_grant_o  replacement-word strobe to the cache set
//   rep_word_o       replacement word to the cache set
//   refill_busy_o    high in REQ, FILL and DONE (fetch stall)
//   refill_done_o    one-cycle pulse when the block is complete
// ---------------------------------------------------------------------------
module instr_cache_refill_ctrl #(
    parameter int B      = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              miss_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    input  logic [63:0]       mem_rdata_i,
    output logic              ic_repl_grant_o,
    output logic [63:0]       rep_word_o,
    output logic              refill_busy_o,
    output logic              refill_done_o
);

    localparam int BEATS = B / 8;
    localparam int CNT_W = $clog2(BEATS);

    // Mask of the byte-offset bits within a block; cleared to align the
    // request address.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(B - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [63:0]       word_reg,  word_next;
    logic              grant_reg, grant_next;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            word_reg  <= '0;
            grant_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            word_reg  <= word_next;
            grant_reg <= grant_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        word_next  = word_reg;
        // Grant is a one-cycle echo of an accepted beat; it drops unless a
        // beat is taken this cycle.
        grant_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (miss_i && !flush_i) begin
                    addr_next  = miss_addr_i & ~OFF_MASK;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end

            REQ: begin
                // Beats are only counted in FILL, so any rvalid seen here,
                // including one coincident with the ack, is discarded.
                if (flush_i) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (mem_ack_i) begin
                    cnt_next   = '0;
                    state_next = FILL;
                end
            end

            FILL: begin
                if (flush_i) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (mem_rvalid_i) begin
                    word_next  = mem_rdata_i;
                    grant_next = 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            DONE: begin
                // Single-cycle state; miss_i and flush_i are not looked at.
                state_next = IDLE;
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, no input feedthrough
    // ------------------------------------------------------------------
    assign mem_req_o       = (state_reg == REQ);
    assign mem_addr_o      = addr_reg;
    assign ic_repl_grant_o = grant_reg;
    assign rep_word_o      = word_reg;
    assign refill_busy_o   = (state_reg != IDLE);
    assign refill_done_o   = (state_reg == DONE);

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for instr_cache_refill_ctrl (B=64, ADDR_W=32).
// Inputs are driven 1 time unit after the rising edge and outputs are
// observed at the same point, i.e. reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_instr_cache_refill_ctrl;

    localparam int B      = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = B / 8;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              miss_i = 1'b0;
    logic [ADDR_W-1:0] miss_addr_i = '0;
    logic              flush_i = 1'b0;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [63:0]       mem_rdata_i = '0;
    logic              ic_repl_grant_o;
    logic [63:0]       rep_word_o;
    logic              refill_busy_o;
    logic              refill_done_o;

    int checks = 0;
    int errors = 0;

    instr_cache_refill_ctrl #(.B(B), .ADDR_W(ADDR_W)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .miss_i          (miss_i),
        .miss_addr_i     (miss_addr_i),
        .flush_i         (flush_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .ic_repl_grant_o (ic_repl_grant_o),
        .rep_word_o      (rep_word_o),
        .refill_busy_o   (refill_busy_o),
        .refill_done_o   (refill_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the edge.
    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    // Beat data: tag in the upper word, beat index mixed into the lower.
    function automatic logic [63:0] dv(input logic [31:0] tag, input int k);
        return {tag, 32'h5A5A_0000 | 32'(k)};
    endfunction

    // Drive a one-cycle miss; leaves the DUT in REQ if it accepted it.
    task automatic do_miss(input logic [ADDR_W-1:0] addr);
        miss_i = 1'b1;
        miss_addr_i = addr;
        cyc;
        miss_i = 1'b0;
        miss_addr_i = '0;
    endtask

    // Ack in the first REQ cycle; leaves the DUT in FILL.
    task automatic do_ack;
        mem_ack_i = 1'b1;
        cyc;
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b0;
        repeat (2) cyc;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", mem_req_o); end
        checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
        checks++; if (ic_repl_grant_o !== 1'b0) begin errors++; $display("FAIL reset_grant got %0b want 0", ic_repl_grant_o); end
        checks++; if (rep_word_o !== '0) begin errors++; $display("FAIL reset_word got %h want 0", rep_word_o); end
        checks++; if (refill_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", refill_busy_o); end
        checks++; if (refill_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", refill_done_o); end
        reset_i = 1'b1;
        cyc;
        checks++; if (refill_busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b want 0", refill_busy_o); end
        $display("test_reset done");
    endtask

    task automatic test_basic_refill;
        int busy_n;
        int done_n;
        busy_n = 0;
        done_n = 0;
        do_miss(32'h0000_1234);
        if (refill_busy_o) busy_n++;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL basic_req got %0b want 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0000_1200) begin errors++; $display("FAIL basic_addr got %h want 00001200", mem_addr_o); end
        do_ack;
        if (refill_busy_o) busy_n++;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %0b want 0", mem_req_o); end
        checks++; if (ic_repl_grant_o !== 1'b0) begin errors++; $display("FAIL basic_grant_pre got %0b want 0", ic_repl_grant_o); end
        for (int k = 0; k < BEATS; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = dv(32'h1111, k);
            cyc;
            if (refill_busy_o) busy_n++;
            if (refill_done_o) done_n++;
            checks++; if (ic_repl_grant_o !== 1'b1 || rep_word_o !== dv(32'h1111, k)) begin
                errors++; $display("FAIL basic_beat%0d got grant=%0b word=%h want grant=1 word=%h", k, ic_repl_grant_o, rep_word_o, dv(32'h1111, k));
            end
            checks++; if (refill_done_o !== (k == BEATS - 1)) begin errors++; $display("FAIL basic_done_beat%0d got %0b want %0b", k, refill_done_o, k == BEATS - 1); end
        end
        mem_rvalid_i = 1'b0;
        cyc;
        if (refill_busy_o) busy_n++;
        if (refill_done_o) done_n++;
        checks++; if (ic_repl_grant_o !== 1'b0 || refill_busy_o !== 1'b0) begin
            errors++; $display("FAIL basic_after got grant=%0b busy=%0b want 0 0", ic_repl_grant_o, refill_busy_o);
        end
        checks++; if (busy_n != 10) begin errors++; $display("FAIL basic_busy_len got %0d want 10", busy_n); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_n); end
        $display("test_basic_refill done");
    endtask

    task automatic test_gapped_beats;
        // Slot pattern, bit i = rvalid in slot i: 2 gaps after beats 1 and 5.
        logic [11:0] pat;
        logic [63:0] exp_word;
        int k;
        int grants;
        pat = 12'hCF3;
        k = 0;
        grants = 0;
        exp_word = '0;
        do_miss(32'h0000_5678);
        checks++; if (mem_addr_o !== 32'h0000_5640) begin errors++; $display("FAIL gap_addr got %h want 00005640", mem_addr_o); end
        do_ack;
        for (int i = 0; i < 12; i++) begin
            mem_rvalid_i = pat[i];
            mem_rdata_i = pat[i] ? dv(32'h2222, k) : 64'hDEAD_BEEF_DEAD_BEEF;
            if (pat[i]) begin
                exp_word = dv(32'h2222, k);
                k++;
            end
            cyc;
            if (ic_repl_grant_o) grants++;
            checks++; if (ic_repl_grant_o !== pat[i] || rep_word_o !== exp_word) begin
                errors++; $display("FAIL gap_slot%0d got grant=%0b word=%h want grant=%0b word=%h", i, ic_repl_grant_o, rep_word_o, pat[i], exp_word);
            end
            checks++; if (refill_done_o !== (i == 11)) begin errors++; $display("FAIL gap_done_slot%0d got %0b want %0b", i, refill_done_o, i == 11); end
        end
        mem_rvalid_i = 1'b0;
        cyc;
        checks++; if (grants != BEATS) begin errors++; $display("FAIL gap_grant_count got %0d want %0d", grants, BEATS); end
        checks++; if (refill_busy_o !== 1'b0) begin errors++; $display("FAIL gap_busy_after got %0b want 0", refill_busy_o); end
        $display("test_gapped_beats done");
    endtask

    task automatic test_delayed_ack;
        do_miss(32'h0000_ABCD);
        for (int i = 0; i < 5; i++) begin
            mem_ack_i = 1'b0;
            mem_rvalid_i = (i == 2);
            mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
            cyc;
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_ABC0 || ic_repl_grant_o !== 1'b0) begin
                errors++; $display("FAIL dly_req%0d got req=%0b addr=%h grant=%0b want 1 0000abc0 0", i, mem_req_o, mem_addr_o, ic_repl_grant_o);
            end
        end
        // Ack and rvalid together: the beat must be ignored.
        mem_ack_i = 1'b1;
        mem_rvalid_i = 1'b1;
        cyc;
        mem_ack_i = 1'b0;
        checks++; if (mem_req_o !== 1'b0 || ic_repl_grant_o !== 1'b0 || refill_busy_o !== 1'b1) begin
            errors++; $display("FAIL dly_ack got req=%0b grant=%0b busy=%0b want 0 0 1", mem_req_o, ic_repl_grant_o, refill_busy_o);
        end
        for (int k = 0; k < BEATS; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = dv(32'h3333, k);
            cyc;
            checks++; if (ic_repl_grant_o !== 1'b1 || rep_word_o !== dv(32'h3333, k) || refill_done_o !== (k == BEATS - 1)) begin
                errors++; $display("FAIL dly_beat%0d got grant=%0b word=%h done=%0b want 1 %h %0b", k, ic_repl_grant_o, rep_word_o, refill_done_o, dv(32'h3333, k), k == BEATS - 1);
            end
        end
        mem_rvalid_i = 1'b0;
        cyc;
        checks++; if (refill_busy_o !== 1'b0) begin errors++; $display("FAIL dly_busy_after got %0b want 0", refill_busy_o); end
        $display("test_delayed_ack done");
    endtask

    task automatic test_flush_fill;
        do_miss(32'h0000_2010);
        do_ack;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = dv(32'h4444, k);
            cyc;
            checks++; if (ic_repl_grant_o !== 1'b1 || rep_word_o !== dv(32'h4444, k)) begin
                errors++; $display("FAIL flush_beat%0d got grant=%0b word=%h want 1 %h", k, ic_repl_grant_o, rep_word_o, dv(32'h4444, k));
            end
        end
        flush_i = 1'b1;
        mem_rdata_i = dv(32'h4444, 4);
        cyc;
        flush_i = 1'b0;
        checks++; if (refill_busy_o !== 1'b0 || ic_repl_grant_o !== 1'b0 || refill_done_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL flush_idle got busy=%0b grant=%0b done=%0b req=%0b want 0 0 0 0", refill_busy_o, ic_repl_grant_o, refill_done_o, mem_req_o);
        end
        for (int k = 5; k < 7; k++) begin
            mem_rdata_i = dv(32'h4444, k);
            cyc;
            checks++; if (refill_busy_o !== 1'b0 || ic_repl_grant_o !== 1'b0 || refill_done_o !== 1'b0) begin
                errors++; $display("FAIL flush_stray%0d got busy=%0b grant=%0b done=%0b want 0 0 0", k, refill_busy_o, ic_repl_grant_o, refill_done_o);
            end
        end
        mem_rvalid_i = 1'b0;
        do_miss(32'h0000_0040);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0040) begin
            errors++; $display("FAIL flush_newreq got req=%0b addr=%h want 1 00000040", mem_req_o, mem_addr_o);
        end
        do_ack;
        for (int k = 0; k < BEATS; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = dv(32'h4545, k);
            cyc;
            checks++; if (ic_repl_grant_o !== 1'b1 || rep_word_o !== dv(32'h4545, k) || refill_done_o !== (k == BEATS - 1)) begin
                errors++; $display("FAIL flush_refill%0d got grant=%0b word=%h done=%0b want 1 %h %0b", k, ic_repl_grant_o, rep_word_o, refill_done_o, dv(32'h4545, k), k == BEATS - 1);
            end
        end
        mem_rvalid_i = 1'b0;
        cyc;
        $display("test_flush_fill done");
    endtask

    task automatic test_async_reset;
        do_miss(32'h0000_3000);
        do_ack;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = dv(32'h5555, k);
            cyc;
        end
        mem_rdata_i = dv(32'h5555, 4);
        #2;
        reset_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== '0 || ic_repl_grant_o !== 1'b0 || rep_word_o !== '0 || refill_busy_o !== 1'b0 || refill_done_o !== 1'b0) begin
            errors++; $display("FAIL areset_now got req=%0b addr=%h grant=%0b word=%h busy=%0b done=%0b want all 0", mem_req_o, mem_addr_o, ic_repl_grant_o, rep_word_o, refill_busy_o, refill_done_o);
        end
        cyc;
        reset_i = 1'b1;
        for (int k = 5; k < BEATS; k++) begin
            mem_rdata_i = dv(32'h5555, k);
            cyc;
            checks++; if (refill_busy_o !== 1'b0 || ic_repl_grant_o !== 1'b0 || rep_word_o !== '0 || refill_done_o !== 1'b0) begin
                errors++; $display("FAIL areset_late%0d got busy=%0b grant=%0b word=%h done=%0b want 0 0 0 0", k, refill_busy_o, ic_repl_grant_o, rep_word_o, refill_done_o);
            end
        end
        mem_rvalid_i = 1'b0;
        cyc;
        $display("test_async_reset done");
    endtask

    task automatic test_back_to_back;
        do_miss(32'h0000_7008);
        do_ack;
        for (int k = 0; k < BEATS; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = dv(32'h6666, k);
            cyc;
        end
        mem_rvalid_i = 1'b0;
        checks++; if (refill_done_o !== 1'b1 || ic_repl_grant_o !== 1'b1 || rep_word_o !== dv(32'h6666, 7)) begin
            errors++; $display("FAIL b2b_done got done=%0b grant=%0b word=%h want 1 1 %h", refill_done_o, ic_repl_grant_o, rep_word_o, dv(32'h6666, 7));
        end
        // In DONE: miss and flush both asserted; neither changes the exit to IDLE.
        miss_i = 1'b1;
        miss_addr_i = 32'h0000_8010;
        flush_i = 1'b1;
        cyc;
        checks++; if (refill_busy_o !== 1'b0 || mem_req_o !== 1'b0 || refill_done_o !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got busy=%0b req=%0b done=%0b want 0 0 0", refill_busy_o, mem_req_o, refill_done_o);
        end
        // Still flushing in IDLE: the miss must not start a refill.
        cyc;
        checks++; if (refill_busy_o !== 1'b0) begin errors++; $display("FAIL b2b_flush_idle got busy=%0b want 0", refill_busy_o); end
        flush_i = 1'b0;
        cyc;
        miss_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_8000) begin
            errors++; $display("FAIL b2b_req got req=%0b addr=%h want 1 00008000", mem_req_o, mem_addr_o);
        end
        // Flush in REQ abandons the request.
        flush_i = 1'b1;
        mem_ack_i = 1'b1;
        cyc;
        flush_i = 1'b0;
        mem_ack_i = 1'b0;
        checks++; if (refill_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL b2b_flush_req got busy=%0b req=%0b want 0 0", refill_busy_o, mem_req_o);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i = dv(32'h6767, 0);
        cyc;
        mem_rvalid_i = 1'b0;
        checks++; if (ic_repl_grant_o !== 1'b0 || refill_busy_o !== 1'b0) begin
            errors++; $display("FAIL b2b_dropped got grant=%0b busy=%0b want 0 0", ic_repl_grant_o, refill_busy_o);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset;
        test_basic_refill;
        test_gapped_beats;
        test_delayed_ack;
        test_flush_fill;
        test_async_reset;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
